// File: rtl/instr_word_loader.sv
// Instruction word loader: assembles UART bytes LSB-first into instruction words
// and writes them to consecutive instruction-memory addresses until halt or full.
module instr_word_loader #(
  parameter int unsigned                   INSTRUCT_MEM_WIDTH = 32,
  parameter int unsigned                   MEM_ADDR_WIDTH     = 8,
  parameter logic [INSTRUCT_MEM_WIDTH-1:0] HALT_WORD          = {INSTRUCT_MEM_WIDTH{1'b1}}
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_load_enable,
  input  logic                          i_rx_done,
  input  logic [7:0]                    i_rx_data,
  output logic                          o_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0]     o_wr_addr,
  output logic [INSTRUCT_MEM_WIDTH-1:0] o_wr_data,
  output logic                          o_load_done,
  output logic                          o_overflow
);

  localparam int unsigned NBYTES = INSTRUCT_MEM_WIDTH / 8;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                          state;
  logic [IDX_W-1:0]                idx;
  logic [MEM_ADDR_WIDTH-1:0]       addr;
  logic [INSTRUCT_MEM_WIDTH-1:0]   word_q;
  logic                            wr_halt;

  logic [INSTRUCT_MEM_WIDTH-1:0]   asm_c;
  logic [MEM_ADDR_WIDTH-1:0]       next_addr_c;
  logic                            finish_c;

  // Word with the incoming byte merged in; address advances once per completed write.
  always_comb begin
    asm_c                      = word_q;
    asm_c[8*int'(idx) +: 8]    = i_rx_data;
    next_addr_c                = o_wr_en ? addr + MEM_ADDR_WIDTH'(1) : addr;
    finish_c                   = o_wr_en && (wr_halt || (o_wr_addr == ADDR_MAX));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      idx         <= '0;
      addr        <= '0;
      word_q      <= '0;
      wr_halt     <= 1'b0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_load_done <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          idx         <= '0;
          addr        <= '0;
          word_q      <= '0;
          o_load_done <= 1'b0;
          o_overflow  <= 1'b0;
          if (i_load_enable) state <= RECV;
        end
        RECV: begin
          if (!i_load_enable) begin
            state  <= IDLE;
            idx    <= '0;
            addr   <= '0;
            word_q <= '0;
          end else if (finish_c) begin
            // Termination takes effect the cycle after the final write strobe.
            state       <= DONE;
            o_load_done <= 1'b1;
            o_overflow  <= !wr_halt;
            idx         <= '0;
            word_q      <= '0;
          end else begin
            addr <= next_addr_c;
            if (i_rx_done) begin
              if (idx == LAST_IDX) begin
                o_wr_en   <= 1'b1;
                o_wr_addr <= next_addr_c;
                o_wr_data <= asm_c;
                wr_halt   <= (asm_c == HALT_WORD);
                idx       <= '0;
                word_q    <= '0;
              end else begin
                idx    <= idx + IDX_W'(1);
                word_q <= asm_c;
              end
            end
          end
        end
        DONE: begin
          if (!i_load_enable) begin
            state       <= IDLE;
            o_load_done <= 1'b0;
            o_overflow  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
